// File: rtl/sdram_cmd_scheduler.sv
// rtl/sdram_cmd_scheduler.sv - post-init SDRAM command scheduler: refresh plus round-robin read/write
`timescale 1ns/1ps
module sdram_cmd_scheduler #(
    parameter int REF_INTERVAL = 390,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int T_WR         = 2,
    parameter int T_RC         = 7,
    parameter int CAS_LAT      = 2,
    parameter int ADDR_W       = 25
) (
    input  logic              iclk,
    input  logic              ctr_reset,
    input  logic              init_fin,
    output logic              init_req,
    output logic              init_enb,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [3:0]        sd_cmd,
    output logic [12:0]       sd_addr,
    output logic [1:0]        sd_ba,
    output logic [1:0]        sd_dqm,
    output logic [15:0]       sd_dq_out,
    output logic              sd_dq_oe,
    input  logic [15:0]       sd_dq_in,
    output logic              busy,
    output logic              ref_overrun
);

    localparam logic [3:0] S_INIT     = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_REF      = 4'd2;
    localparam logic [3:0] S_REF_WAIT = 4'd3;
    localparam logic [3:0] S_ACT      = 4'd4;
    localparam logic [3:0] S_RCD_WAIT = 4'd5;
    localparam logic [3:0] S_WR       = 4'd6;
    localparam logic [3:0] S_RD       = 4'd7;
    localparam logic [3:0] S_RD_DATA  = 4'd8;
    localparam logic [3:0] S_RECOVER  = 4'd9;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_REF   = 4'b0001;

    localparam int REF_W = $clog2(REF_INTERVAL);
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REF_INTERVAL - 1);
    localparam logic [REF_W-1:0] REF_ONE    = REF_W'(1);

    localparam logic [7:0] RC_LOAD  = 8'(T_RC - 2);
    localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 2);
    localparam logic [7:0] WR_LOAD  = 8'(T_WR + T_RP - 1);
    localparam logic [7:0] RP_LOAD  = 8'(T_RP - 1);
    localparam logic [7:0] CAS_C    = 8'(CAS_LAT);
    localparam logic [7:0] RD_LAST  = 8'(CAS_LAT + 7);

    logic [3:0]        state, state_d;
    logic [7:0]        wcnt, wcnt_d;
    logic              job_rd, job_rd_d;
    logic [ADDR_W-1:0] job_addr, job_addr_d;
    logic [15:0]       job_data, job_data_d;
    logic              rr_last_rd, rr_last_rd_d;
    logic [REF_W-1:0]  ref_cnt;
    logic              ref_pending;
    logic              ref_go;
    logic              capture;

    logic [1:0]  nxt_bank;
    logic [12:0] nxt_row;
    logic [12:0] nxt_col_wr;
    logic [12:0] nxt_col_rd;

    assign nxt_bank   = job_addr_d[ADDR_W-1 -: 2];
    assign nxt_row    = job_addr_d[ADDR_W-3 -: 13];
    assign nxt_col_wr = {3'b001, job_addr_d[9:0]};
    assign nxt_col_rd = {3'b001, job_addr_d[9:3], 3'b000};

    // Burst words are on the DQ pins from CAS_LAT through CAS_LAT+7 cycles after READ.
    assign capture = (state == S_RD_DATA) && (wcnt >= CAS_C);

    always_comb begin
        state_d      = state;
        wcnt_d       = wcnt;
        job_rd_d     = job_rd;
        job_addr_d   = job_addr;
        job_data_d   = job_data;
        rr_last_rd_d = rr_last_rd;
        ref_go       = 1'b0;
        case (state)
            S_INIT: if (init_fin) state_d = S_IDLE;
            S_IDLE: begin
                // An expiry this very cycle already beats a request.
                if (ref_pending || ref_cnt == '0) begin
                    ref_go  = 1'b1;
                    state_d = S_REF;
                end else if (rd_req && (!wr_req || !rr_last_rd)) begin
                    state_d      = S_ACT;
                    job_rd_d     = 1'b1;
                    job_addr_d   = rd_addr;
                    rr_last_rd_d = 1'b1;
                end else if (wr_req) begin
                    state_d      = S_ACT;
                    job_rd_d     = 1'b0;
                    job_addr_d   = wr_addr;
                    job_data_d   = wr_data;
                    rr_last_rd_d = 1'b0;
                end
            end
            S_REF: begin
                state_d = S_REF_WAIT;
                wcnt_d  = RC_LOAD;
            end
            S_REF_WAIT: if (wcnt == '0) state_d = S_IDLE; else wcnt_d = wcnt - 8'd1;
            S_ACT: begin
                state_d = S_RCD_WAIT;
                wcnt_d  = RCD_LOAD;
            end
            S_RCD_WAIT: if (wcnt == '0) state_d = job_rd ? S_RD : S_WR; else wcnt_d = wcnt - 8'd1;
            S_WR: begin
                state_d = S_RECOVER;
                wcnt_d  = WR_LOAD;
            end
            S_RD: begin
                state_d = S_RD_DATA;
                wcnt_d  = 8'd1;
            end
            S_RD_DATA: begin
                if (wcnt == RD_LAST) begin
                    state_d = S_RECOVER;
                    wcnt_d  = RP_LOAD;
                end else begin
                    wcnt_d = wcnt + 8'd1;
                end
            end
            S_RECOVER: if (wcnt == '0) state_d = S_IDLE; else wcnt_d = wcnt - 8'd1;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            state       <= S_INIT;
            wcnt        <= '0;
            job_rd      <= 1'b0;
            job_addr    <= '0;
            job_data    <= '0;
            rr_last_rd  <= 1'b0;
            ref_cnt     <= REF_RELOAD;
            ref_pending <= 1'b0;
            ref_overrun <= 1'b0;
            sd_cmd      <= CMD_NOP;
            sd_addr     <= '0;
            sd_ba       <= '0;
            sd_dqm      <= 2'b11;
            sd_dq_out   <= '0;
            sd_dq_oe    <= 1'b0;
            wr_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            init_req    <= 1'b0;
            init_enb    <= 1'b1;
            busy        <= 1'b1;
        end else begin
            state      <= state_d;
            wcnt       <= wcnt_d;
            job_rd     <= job_rd_d;
            job_addr   <= job_addr_d;
            job_data   <= job_data_d;
            rr_last_rd <= rr_last_rd_d;

            if (state != S_INIT) begin
                if (ref_cnt == '0) begin
                    ref_cnt <= REF_RELOAD;
                    if (ref_pending) ref_overrun <= 1'b1;
                    ref_pending <= !ref_go;
                end else begin
                    ref_cnt <= ref_cnt - REF_ONE;
                    if (ref_go) ref_pending <= 1'b0;
                end
            end

            // Pin outputs follow the state being entered so they line up with state.
            sd_cmd    <= CMD_NOP;
            sd_addr   <= '0;
            sd_ba     <= '0;
            sd_dq_out <= '0;
            sd_dq_oe  <= 1'b0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            case (state_d)
                S_REF: sd_cmd <= CMD_REF;
                S_ACT: begin
                    sd_cmd  <= CMD_ACT;
                    sd_ba   <= nxt_bank;
                    sd_addr <= nxt_row;
                end
                S_WR: begin
                    sd_cmd    <= CMD_WRITE;
                    sd_ba     <= nxt_bank;
                    sd_addr   <= nxt_col_wr;
                    sd_dq_out <= job_data_d;
                    sd_dq_oe  <= 1'b1;
                    wr_ack    <= 1'b1;
                end
                S_RD: begin
                    sd_cmd  <= CMD_READ;
                    sd_ba   <= nxt_bank;
                    sd_addr <= nxt_col_rd;
                    rd_ack  <= 1'b1;
                end
                default: ;
            endcase
            sd_dqm   <= (state_d == S_INIT) ? 2'b11 : 2'b00;
            init_req <= (state_d == S_INIT);
            init_enb <= (state_d == S_INIT);
            busy     <= (state_d != S_IDLE);
            rd_valid <= capture;
            if (capture) rd_data <= sd_dq_in;
        end
    end

endmodule
